// File: rtl/phased_pulse_generator.sv
// Multi-channel phased pulse generator: one shared bipolar burst per frame, delayed per
// channel, with dead-time inserted at polarity changes. All outputs come from registers.
module phased_pulse_generator #(
  parameter int N_CH  = 4,
  parameter int PAT_W = 32,
  parameter int CNT_W = 32,
  parameter int DLY_W = 16,
  parameter int DEAD  = 2,
  localparam int PL_W  = $clog2(PAT_W) + 1,
  localparam int IDX_W = $clog2(PAT_W)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic [PAT_W-1:0]        pattern,
  input  logic [PL_W-1:0]         pulse_len,
  input  logic [15:0]             half_period,
  input  logic [CNT_W-1:0]        tx_period,
  input  logic [N_CH*DLY_W-1:0]   ch_delay,
  input  logic [N_CH-1:0]         ch_mask,
  output logic [N_CH-1:0]         tx_p,
  output logic [N_CH-1:0]         tx_n,
  output logic                    frame_start,
  output logic                    busy
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [15:0] DEAD_C = 16'(DEAD);

  state_t                  state, state_nxt;
  logic [CNT_W-1:0]        cnt, cnt_nxt;
  logic                    new_frame;

  logic [PAT_W-1:0]        sh_pat;
  logic [IDX_W-1:0]        sh_pl, pl_clamped;
  logic [15:0]             sh_hp;
  logic [CNT_W-1:0]        sh_tp;
  logic [N_CH*DLY_W-1:0]   sh_dly;
  logic [N_CH-1:0]         sh_mask;

  // Per-channel burst engine: active flag, cycle within bit, bit index, bit value,
  // and whether the current bit changed polarity (so its first cycles are dead-time).
  logic [N_CH-1:0]         act, act_n;
  logic [15:0]             hcnt   [N_CH];
  logic [15:0]             hcnt_n [N_CH];
  logic [IDX_W-1:0]        bidx   [N_CH];
  logic [IDX_W-1:0]        bidx_n [N_CH];
  logic [N_CH-1:0]         bitv, bitv_n;
  logic [N_CH-1:0]         dbit, dbit_n;
  logic [N_CH-1:0]         txp_n, txn_n;

  assign pl_clamped = (pulse_len > PL_W'(PAT_W - 1)) ? IDX_W'(PAT_W - 1)
                                                      : pulse_len[IDX_W-1:0];

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    new_frame = 1'b0;
    case (state)
      IDLE: begin
        if (enable) begin
          state_nxt = RUN;
          cnt_nxt   = '0;
          new_frame = 1'b1;
        end
      end
      RUN: begin
        if (cnt == sh_tp) begin
          cnt_nxt = '0;
          if (enable) new_frame = 1'b1;
          else        state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Frame cycle 0 never carries a burst cycle, so channels are cleared there and the
  // freshly latched shadow values are only consulted from cycle 1 onward.
  always_comb begin
    act_n  = '0;
    bitv_n = bitv;
    dbit_n = dbit;
    txp_n  = '0;
    txn_n  = '0;
    for (int i = 0; i < N_CH; i++) begin
      hcnt_n[i] = hcnt[i];
      bidx_n[i] = bidx[i];
      if (state_nxt == RUN && !new_frame) begin
        if (sh_mask[i] && ({1'b0, cnt_nxt} ==
            (CNT_W+1)'(sh_dly[i*DLY_W +: DLY_W]) + (CNT_W+1)'(1))) begin
          act_n[i]  = 1'b1;
          hcnt_n[i] = '0;
          bidx_n[i] = sh_pl;
          bitv_n[i] = sh_pat[sh_pl];
          dbit_n[i] = 1'b0;
        end else if (act[i]) begin
          if (hcnt[i] == sh_hp) begin
            if (bidx[i] != '0) begin
              act_n[i]  = 1'b1;
              hcnt_n[i] = '0;
              bidx_n[i] = bidx[i] - 1'b1;
              bitv_n[i] = sh_pat[bidx[i] - 1'b1];
              dbit_n[i] = sh_pat[bidx[i] - 1'b1] != bitv[i];
            end
          end else begin
            act_n[i]  = 1'b1;
            hcnt_n[i] = hcnt[i] + 1'b1;
          end
        end
      end
      if (act_n[i] && !(dbit_n[i] && hcnt_n[i] < DEAD_C)) begin
        txp_n[i] = bitv_n[i];
        txn_n[i] = ~bitv_n[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      sh_pat      <= '0;
      sh_pl       <= '0;
      sh_hp       <= '0;
      sh_tp       <= '0;
      sh_dly      <= '0;
      sh_mask     <= '0;
      act         <= '0;
      bitv        <= '0;
      dbit        <= '0;
      tx_p        <= '0;
      tx_n        <= '0;
      frame_start <= 1'b0;
      busy        <= 1'b0;
      for (int i = 0; i < N_CH; i++) begin
        hcnt[i] <= '0;
        bidx[i] <= '0;
      end
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      act         <= act_n;
      bitv        <= bitv_n;
      dbit        <= dbit_n;
      tx_p        <= txp_n;
      tx_n        <= txn_n;
      frame_start <= new_frame;
      busy        <= |act_n;
      for (int i = 0; i < N_CH; i++) begin
        hcnt[i] <= hcnt_n[i];
        bidx[i] <= bidx_n[i];
      end
      if (new_frame) begin
        sh_pat  <= pattern;
        sh_pl   <= pl_clamped;
        sh_hp   <= half_period;
        sh_tp   <= tx_period;
        sh_dly  <= ch_delay;
        sh_mask <= ch_mask;
      end
    end
  end

endmodule

// File: tb/tb_phased_pulse_generator.sv
// Bench for phased_pulse_generator: per-cycle expected vectors {frame_start,busy,tx_p,tx_n}
// are queued by the stimulus and checked by an independent negedge monitor.
module tb_phased_pulse_generator;

  localparam int N = 4;
  localparam int W = 2 + 2 * N;
  localparam int DEAD = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            enable;
  logic [31:0]     pattern;
  logic [5:0]      pulse_len;
  logic [15:0]     half_period;
  logic [31:0]     tx_period;
  logic [N*16-1:0] ch_delay;
  logic [N-1:0]    ch_mask;
  logic [N-1:0]    tx_p, tx_n;
  logic            frame_start, busy;

  phased_pulse_generator dut (
    .clk(clk), .rst(rst), .enable(enable), .pattern(pattern), .pulse_len(pulse_len),
    .half_period(half_period), .tx_period(tx_period), .ch_delay(ch_delay),
    .ch_mask(ch_mask), .tx_p(tx_p), .tx_n(tx_n), .frame_start(frame_start), .busy(busy)
  );

  always #5 clk = ~clk;

  logic [W-1:0]    exp_q[$];
  int              total = 0;
  int              bad = 0;
  bit              done = 0;

  // parameters in force for the frame being modelled
  logic [31:0]     e_pat;
  logic [5:0]      e_pl;
  logic [15:0]     e_hp;
  logic [31:0]     e_tp;
  logic [N*16-1:0] e_dly;
  logic [N-1:0]    e_mask;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%b want=%b", name, $time, act, exp);
    end
  endtask

  // Expected outputs at frame cycle c, from the burst-window arithmetic directly.
  function automatic logic [W-1:0] model(input int c);
    logic [N-1:0] p, n;
    logic b;
    int pl, hp, len, d, k, bi, w, idx;
    p = '0; n = '0; b = 1'b0;
    pl = (int'(e_pl) > 31) ? 31 : int'(e_pl);
    hp = int'(e_hp);
    len = (pl + 1) * (hp + 1);
    for (int i = 0; i < N; i++) begin
      d = int'(e_dly[i*16 +: 16]);
      k = c - d - 1;
      if (e_mask[i] && k >= 0 && k < len) begin
        b = 1'b1;
        bi = k / (hp + 1);
        w = k % (hp + 1);
        idx = pl - bi;
        if (!(bi > 0 && e_pat[idx] != e_pat[idx+1] && w < DEAD)) begin
          p[i] = e_pat[idx];
          n[i] = ~e_pat[idx];
        end
      end
    end
    return {c == 0, b, p, n};
  endfunction

  always @(negedge clk) begin
    if (!done) begin
      if (exp_q.size() > 0) chk("cycle", {frame_start, busy, tx_p, tx_n}, exp_q.pop_front());
      total++;
      if ((tx_p & tx_n) != '0) begin
        bad++;
        $display("FAIL overlap t=%0t tx_p=%b tx_n=%b want no common bit", $time, tx_p, tx_n);
      end
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      exp_q.push_back('0);
    end
  endtask

  // Runs one frame starting at the next edge; optionally clears pattern and drops enable
  // at chg_at, or asserts reset between edges at rst_at and abandons the frame.
  task automatic frame(input bit keep, input int chg_at, input int rst_at);
    e_pat = pattern; e_pl = pulse_len; e_hp = half_period;
    e_tp = tx_period; e_dly = ch_delay; e_mask = ch_mask;
    for (int c = 0; c <= int'(e_tp); c++) begin
      @(posedge clk); #1;
      if (c == rst_at) begin
        #2 rst = 1'b1;
        #1 chk("async_rst", {frame_start, busy, tx_p, tx_n}, '0);
        exp_q.push_back('0);
        return;
      end
      exp_q.push_back(model(c));
      if (c == chg_at) begin
        pattern = '0;
        enable = 1'b0;
      end
      if (c == int'(e_tp)) enable = keep;
    end
  endtask

  task automatic set_params(input logic [31:0] pat, input logic [5:0] pl, input logic [15:0] hp,
                            input logic [31:0] tp, input logic [N*16-1:0] dly,
                            input logic [N-1:0] mask);
    pattern = pat; pulse_len = pl; half_period = hp;
    tx_period = tp; ch_delay = dly; ch_mask = mask;
  endtask

  initial begin
    rst = 1'b1;
    enable = 1'b0;
    set_params(32'hFF0055AA, 6'd31, 16'd9, 32'd4999, {16'd30, 16'd20, 16'd10, 16'd0}, 4'hF);
    @(posedge clk); @(posedge clk); #1;
    chk("reset_state", {frame_start, busy, tx_p, tx_n}, '0);
    rst = 1'b0;
    idle(3);

    // basic burst, two back-to-back frames; second is shadow-tested and stops
    enable = 1'b1;
    frame(1'b1, -1, -1);
    frame(1'b0, 200, -1);
    idle(10);

    // truncation of channel 3, twice so the next frame's cycle 0 is seen low
    set_params(32'hFF0055AA, 6'd31, 16'd9, 32'd99, {16'd90, 16'd20, 16'd10, 16'd0}, 4'hF);
    enable = 1'b1;
    frame(1'b1, -1, -1);
    frame(1'b1, -1, -1);

    // dead-time consumes every bit after the first
    set_params(32'hAAAAAAAA, 6'd31, 16'd1, 32'd99, {16'd0, 16'd3, 16'd0, 16'd0}, 4'hF);
    frame(1'b1, -1, -1);

    // mask and pulse_len clamp
    set_params(32'hC3A5F00F, 6'd40, 16'd9, 32'd399, {16'd15, 16'd10, 16'd5, 16'd0}, 4'b0101);
    frame(1'b1, -1, -1);

    // reset mid-burst, then restart with enable held
    set_params(32'hFF0055AA, 6'd31, 16'd9, 32'd199, {16'd30, 16'd20, 16'd10, 16'd0}, 4'hF);
    frame(1'b1, -1, 40);
    idle(2);
    rst = 1'b0;
    frame(1'b0, -1, -1);
    idle(5);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain left=%0d want=0", exp_q.size());
    end
    @(posedge clk);
    done = 1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/phased_pulse_generator.md
Name: phased_pulse_generator

Overview:
- Multi-channel successor to the single-channel ultrasound pulse generator.
- Drives N_CH transducer H-bridge pairs (tx_p/tx_n) with a shared bipolar pattern burst.
- Each burst is delayed per channel for beam steering, with programmable dead-time at polarity changes.
- Sits between the sonar control registers and the transmit driver pins; frame_start marks the start of each frame for the receive/ADC capture path.

Parameters:
N_CH, 4, number of transmit channels
PAT_W, 32, pattern register width in bits
CNT_W, 32, width of tx_period frame counter
DLY_W, 16, width of each per-channel delay
DEAD, 2, dead-time clocks with both outputs low when bit polarity changes

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
enable  in  1  level; run continuous frames while high
pattern  in  PAT_W  burst bit pattern, 1 = positive drive (tx_p), 0 = negative drive (tx_n)
pulse_len  in  $clog2(PAT_W)+1  number of burst bits minus 1
half_period  in  16  clocks per bit minus 1
tx_period  in  CNT_W  frame length in clocks minus 1
ch_delay  in  N_CH*DLY_W  channel i delay in clocks, at [i*DLY_W +: DLY_W]
ch_mask  in  N_CH  1 = channel enabled
tx_p  out  N_CH  positive drive per channel
tx_n  out  N_CH  negative drive per channel
frame_start  out  1  one-cycle pulse in the first cycle of each frame
busy  out  1  high while any channel is mid-burst

Behaviour:
- Reset (async, rst=1): tx_p=0, tx_n=0, frame_start=0, busy=0. Frame counter is cleared and the state goes to IDLE immediately, including mid-burst.
- States are IDLE and RUN.
- IDLE → RUN: on a clk edge with enable=1. frame_start=1 in the following cycle (frame cycle 0).
- Shadow latch at frame cycle 0: pattern, pulse_len, half_period, tx_period, ch_delay and ch_mask are all captured. Input changes mid-frame have no effect until the next frame.
- pulse_len clamp: values above PAT_W-1 clamp to PAT_W-1.
- Bit order: burst bits are pattern[pulse_len] down to pattern[0], MSB first.
- Frame length: tx_period+1 cycles.
- RUN at the end of a frame: at the last frame cycle, if enable=1 the next cycle is frame cycle 0 of a new frame. Otherwise the state returns to IDLE.
- enable deassert mid-frame: the current frame always completes.
- Channel i, masked on: the burst occupies frame cycles d_i+1 through d_i+(pulse_len+1)*(half_period+1), where d_i = ch_delay[i].
  - Each bit lasts half_period+1 cycles.
  - Bit=1 drives tx_p=1, tx_n=0.
  - Bit=0 drives tx_p=0, tx_n=1.
- Dead-time: if a bit's polarity differs from the previous bit of the same burst, the first min(DEAD, half_period+1) cycles of that bit drive both outputs 0. The first bit of a burst gets no dead-time.
- Outside its burst window, and when masked off, a channel drives tx_p=0, tx_n=0.
- Truncation: a burst extending past the frame end is cut at frame cycle tx_period. The channel is idle from the next frame cycle 0, and the new burst then starts afresh.
- Invariant: tx_p[i] & tx_n[i] is never 1, in any cycle or channel.
- busy: high in any cycle where any unmasked channel is inside its burst window, dead-time cycles included.
- Outputs are registered, so no combinational path exists from any input to tx_p/tx_n.
- Arithmetic: burst-window comparisons use CNT_W+1 bits, so a window end beyond 2^CNT_W does not wrap. It is treated as truncated.

Test Plan:
- Basic burst: N_CH=4, pattern=32'hFF0055AA, pulse_len=31, half_period=9, tx_period=4999, delays 0/10/20/30, mask=4'hF, enable held high → frame_start every 5000 cycles.
  - Channel 0 tx_p high at frame cycles 1–80; dead-time 2 cycles at the first 1→0 transition.
  - Each channel's waveform equals channel 0's shifted by 10·i cycles.
  - The tx_p&tx_n overlap check never fires.
- Dead-time edge: half_period=1, DEAD=2, pattern=32'hAAAAAAAA → every bit after the first is all-low on both outputs. busy stays high for 64 cycles.
- Truncation: tx_period=99, ch_delay[3]=90, pulse_len=31, half_period=9 → channel 3 is active at frame cycles 91–99 only. It is low at cycle 0 of the next frame.
- Shadowing and stop: change pattern to 32'h0 and drop enable at frame cycle 200.
  - The current frame keeps the old pattern and completes through cycle 4999.
  - frame_start does not reassert; outputs stay 0 and busy=0.
- Reset mid-burst: assert rst at frame cycle 40 asynchronously, between clk edges → tx_p/tx_n/busy go 0 without waiting for an edge.
  - After release with enable=1, frame_start asserts one cycle after the first edge.
- Mask and clamp: ch_mask=4'b0101, pulse_len=40 → channels 1 and 3 stay 0 throughout. Channels 0 and 2 emit 32 bits, i.e. pulse_len clamped to 31.
